photonic_switch_sequencer: RTL and testbench

Single-port command sequencer driving the set (S) and reset (R) pulse inputs of a bank of latching photonic-switch flip-flops. Accepts one switch command at a time over a valid/ready handshake and emits a fixed-width pulse on the selected switch's S or R line. It then holds off further commands for a settle window so the optical element can stabilise. The block tracks the commanded state of every switch and sits between the host command path and the per-switch S/R flip-flops.

---
 rtl/photonic_switch_sequencer_if.sv | 22 ++
 rtl/photonic_switch_sequencer.sv | 173 +++++++++++++++++
 tb/tb_photonic_switch_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/photonic_switch_sequencer_if.sv
// Command handshake between the host and photonic_switch_sequencer: a valid/ready
// request carrying the switch index and set/reset polarity, plus done/err strobes.
interface photonic_switch_sequencer_if #(
    parameter int SW_W = 2
) ();
    logic            req_valid;
    logic            req_ready;
    logic [SW_W-1:0] req_sw;
    logic            req_set;
    logic            done;
    logic            err;

    modport master (
        output req_valid, req_sw, req_set,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_sw, req_set,
        output req_ready, done, err
    );
endinterface

// File: rtl/photonic_switch_sequencer.sv
// Sequences S/R pulses for a bank of latching photonic switches, one command at a time,
// with a settle window after each pulse. Optional build macro: SKIP_REDUNDANT_EN.
module photonic_switch_sequencer #(
    parameter int N_SW    = 4,
    parameter int PULSE_W = 8,
    parameter int SETTLE  = 16,
    parameter int SW_W    = (N_SW > 1) ? $clog2(N_SW) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    photonic_switch_sequencer_if.slave cmd,
    output logic [N_SW-1:0]            sw_s,
    output logic [N_SW-1:0]            sw_r,
    output logic [N_SW-1:0]            sw_state
);

    localparam int CNT_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_SW-1:0]  r_sw_s;
    logic [N_SW-1:0]  r_sw_r;
    logic [N_SW-1:0]  r_sw_state;
    logic [N_SW-1:0]  r_sel;
    logic             r_set;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [N_SW-1:0]  w_sw_s_nxt;
    logic [N_SW-1:0]  w_sw_r_nxt;
    logic [N_SW-1:0]  w_sw_state_nxt;
    logic [N_SW-1:0]  w_sel_nxt;
    logic             w_set_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    logic [N_SW-1:0]  w_sel;
    logic             w_in_range;
    logic             w_redundant;

    // One-hot decode of the requested index; an out-of-range index decodes to all zeros.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (cmd.req_sw == SW_W'(i)) begin
                w_sel[i] = 1'b1;
            end
        end
    end

    assign w_in_range = |w_sel;

`ifdef SKIP_REDUNDANT_EN
    assign w_redundant = ((|(r_sw_state & w_sel)) == cmd.req_set);
`else
    assign w_redundant = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_sw_s_nxt     = r_sw_s;
        w_sw_r_nxt     = r_sw_r;
        w_sw_state_nxt = r_sw_state;
        w_sel_nxt      = r_sel;
        w_set_nxt      = r_set;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd.req_valid) begin
                    if (!w_in_range) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else if (w_redundant) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = PULSE_LD;
                        w_sel_nxt   = w_sel;
                        w_set_nxt   = cmd.req_set;
                        w_sw_s_nxt  = cmd.req_set ? w_sel : '0;
                        w_sw_r_nxt  = cmd.req_set ? '0 : w_sel;
                        w_sw_state_nxt = cmd.req_set ? (r_sw_state | w_sel)
                                                     : (r_sw_state & ~w_sel);
                    end
                end
            end

            ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_sw_s_nxt = '0;
                    w_sw_r_nxt = '0;
                    if (SETTLE > 0) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = SETTLE_LD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    w_sw_s_nxt = r_set ? r_sel : '0;
                    w_sw_r_nxt = r_set ? '0 : r_sel;
                end
            end

            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_sw_s_nxt  = '0;
                w_sw_r_nxt  = '0;
            end
        endcase
    end

    // Reset drops any pulse in flight immediately so no switch sees a truncated-then-resumed drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sw_s     <= '0;
            r_sw_r     <= '0;
            r_sw_state <= '0;
            r_sel      <= '0;
            r_set      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sw_s     <= w_sw_s_nxt;
            r_sw_r     <= w_sw_r_nxt;
            r_sw_state <= w_sw_state_nxt;
            r_sel      <= w_sel_nxt;
            r_set      <= w_set_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign cmd.req_ready = (r_state == ST_IDLE);
    assign cmd.done      = r_done;
    assign cmd.err       = r_err;
    assign sw_s          = r_sw_s;
    assign sw_r          = r_sw_r;
    assign sw_state      = r_sw_state;

endmodule

// File: tb/tb_photonic_switch_sequencer.sv
// Directed bench for photonic_switch_sequencer: a command table plus hand-written sequences
// for back-to-back, mid-pulse reset and a SETTLE=0 build. Honours SKIP_REDUNDANT_EN.
module tb_photonic_switch_sequencer;

    localparam int NSW = 4;
    localparam int PW  = 3;
    localparam int ST  = 5;
    localparam int SWW = 3;

    logic clk;
    logic reset_n;
    logic [NSW-1:0] sw_s, sw_r, sw_state;
    logic [NSW-1:0] sw_s0, sw_r0, sw_state0;

    int n_checks;
    int n_err;

    photonic_switch_sequencer_if #(.SW_W(SWW)) cif ();
    photonic_switch_sequencer_if #(.SW_W(SWW)) cif0 ();

    photonic_switch_sequencer #(
        .N_SW(NSW), .PULSE_W(PW), .SETTLE(ST), .SW_W(SWW)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .cmd(cif.slave),
        .sw_s(sw_s), .sw_r(sw_r), .sw_state(sw_state)
    );

    photonic_switch_sequencer #(
        .N_SW(NSW), .PULSE_W(1), .SETTLE(0), .SW_W(SWW)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cmd(cif0.slave),
        .sw_s(sw_s0), .sw_r(sw_r0), .sw_state(sw_state0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sw;
        bit         set;
        logic [3:0] exp_s;
        logic [3:0] exp_r;
        logic [3:0] exp_state;
        bit         exp_err;
        bit         exp_pulse;
    } cmd_vec_t;

    cmd_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command on the main DUT and check every cycle up to and including done.
    task automatic run_cmd(input cmd_vec_t v, input string nm);
        int last;
        logic [3:0] es, er;
        last = v.exp_pulse ? (PW + ST + 1) : 1;
        check({nm, " ready_before"}, 32'(cif.req_ready), 32'd1);
        cif.req_valid = 1'b1;
        cif.req_sw    = SWW'(v.sw);
        cif.req_set   = v.set;
        @(negedge clk);
        cif.req_valid = 1'b0;
        for (int k = 1; k <= last; k++) begin
            if (k > 1) @(negedge clk);
            es = (v.exp_pulse && k <= PW) ? v.exp_s : 4'b0000;
            er = (v.exp_pulse && k <= PW) ? v.exp_r : 4'b0000;
            check($sformatf("%s c%0d sw_s", nm, k), 32'(sw_s), 32'(es));
            check($sformatf("%s c%0d sw_r", nm, k), 32'(sw_r), 32'(er));
            check($sformatf("%s c%0d sw_state", nm, k), 32'(sw_state), 32'(v.exp_state));
            check($sformatf("%s c%0d done", nm, k), 32'(cif.done), 32'(k == last));
            check($sformatf("%s c%0d err", nm, k), 32'(cif.err), 32'(k == last && v.exp_err));
            check($sformatf("%s c%0d ready", nm, k), 32'(cif.req_ready), 32'(k == last));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] es, er, est;
        bit         ed;
        n_checks = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        cif.req_valid  = 1'b0; cif.req_sw  = '0; cif.req_set  = 1'b0;
        cif0.req_valid = 1'b0; cif0.req_sw = '0; cif0.req_set = 1'b0;

        //             sw set  exp_s    exp_r    state    err   pulse
        vecs[0] = '{2, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1};
        vecs[1] = '{5, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0};
        vecs[2] = '{1, 1'b1, 4'b0010, 4'b0000, 4'b0110, 1'b0, 1'b1};
`ifdef SKIP_REDUNDANT_EN
        vecs[3] = '{1, 1'b1, 4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b0};
`else
        vecs[3] = '{1, 1'b1, 4'b0010, 4'b0000, 4'b0110, 1'b0, 1'b1};
`endif
        vecs[4] = '{2, 1'b0, 4'b0000, 4'b0100, 4'b0010, 1'b0, 1'b1};
`ifdef SKIP_REDUNDANT_EN
        vecs[5] = '{3, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0};
`else
        vecs[5] = '{3, 1'b0, 4'b0000, 4'b1000, 4'b0010, 1'b0, 1'b1};
`endif
        vecs[6] = '{7, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0};
        vecs[7] = '{0, 1'b1, 4'b0001, 4'b0000, 4'b0011, 1'b0, 1'b1};

        // Values held in reset.
        repeat (2) @(negedge clk);
        check("rst sw_s", 32'(sw_s), 32'd0);
        check("rst sw_r", 32'(sw_r), 32'd0);
        check("rst sw_state", 32'(sw_state), 32'd0);
        check("rst done", 32'(cif.done), 32'd0);
        check("rst err", 32'(cif.err), 32'd0);
        check("rst ready", 32'(cif.req_ready), 32'd1);
        check("rst0 ready", 32'(cif0.req_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check("post_table done", 32'(cif.done), 32'd0);
        check("post_table err", 32'(cif.err), 32'd0);

        // Back-to-back: sw0 set, then sw0 reset with req_valid held across the first command.
        pulse_reset();
        cif.req_valid = 1'b1;
        cif.req_sw    = 3'd0;
        cif.req_set   = 1'b1;
        @(negedge clk);
        cif.req_set = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) @(negedge clk);
            es  = (k >= 1  && k <= 3)  ? 4'b0001 : 4'b0000;
            er  = (k >= 10 && k <= 12) ? 4'b0001 : 4'b0000;
            est = (k < 10) ? 4'b0001 : 4'b0000;
            ed  = (k == 9 || k == 18);
            check($sformatf("b2b c%0d sw_s", k), 32'(sw_s), 32'(es));
            check($sformatf("b2b c%0d sw_r", k), 32'(sw_r), 32'(er));
            check($sformatf("b2b c%0d sw_state", k), 32'(sw_state), 32'(est));
            check($sformatf("b2b c%0d done", k), 32'(cif.done), 32'(ed));
            check($sformatf("b2b c%0d ready", k), 32'(cif.req_ready), 32'(ed));
            if (k == 10) cif.req_valid = 1'b0;
        end

        // Reset asserted in cycle 2 of an S pulse.
        @(negedge clk);
        cif.req_valid = 1'b1;
        cif.req_sw    = 3'd2;
        cif.req_set   = 1'b1;
        @(negedge clk);
        cif.req_valid = 1'b0;
        check("midrst c1 sw_s", 32'(sw_s), 32'b0100);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst sw_s", 32'(sw_s), 32'd0);
        check("midrst sw_r", 32'(sw_r), 32'd0);
        check("midrst sw_state", 32'(sw_state), 32'd0);
        check("midrst ready", 32'(cif.req_ready), 32'd1);
        check("midrst done", 32'(cif.done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_cmd('{3, 1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1}, "after_rst");

        // SETTLE=0, PULSE_W=1 build.
        cif0.req_valid = 1'b1;
        cif0.req_sw    = 3'd1;
        cif0.req_set   = 1'b1;
        @(negedge clk);
        cif0.req_valid = 1'b0;
        check("s0 c1 sw_s", 32'(sw_s0), 32'b0010);
        check("s0 c1 sw_state", 32'(sw_state0), 32'b0010);
        check("s0 c1 ready", 32'(cif0.req_ready), 32'd0);
        check("s0 c1 done", 32'(cif0.done), 32'd0);
        @(negedge clk);
        check("s0 c2 sw_s", 32'(sw_s0), 32'd0);
        check("s0 c2 done", 32'(cif0.done), 32'd1);
        check("s0 c2 ready", 32'(cif0.req_ready), 32'd1);
        @(negedge clk);
        check("s0 c3 done", 32'(cif0.done), 32'd0);
        check("s0 c3 sw_r", 32'(sw_r0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
